// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_sequencer : iterative signed multiply (radix-2 Booth) and          |
// |                    restoring divide with its own sequencing FSM           |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int             c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MULT = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               r_state, w_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [WIDTH:0]       r_acc;      // Booth accumulator / partial remainder
    logic [WIDTH-1:0]     r_q;        // multiplier / dividend-then-quotient
    logic                 r_q1;
    logic [WIDTH-1:0]     r_m;        // multiplicand / divisor magnitude
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_div0;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_ready;
    logic                 w_acc_mult;
    logic                 w_acc_div;
    logic                 w_div_zero;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_booth;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_sub;
    logic                 w_div_ge;

    assign w_ready    = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_acc_mult = w_ready && start_mult;
    assign w_acc_div  = w_ready && !start_mult && start_div && (b != '0);
    assign w_div_zero = w_ready && !start_mult && start_div && (b == '0);

    assign w_abs_a = a[WIDTH-1] ? -a : a;
    assign w_abs_b = b[WIDTH-1] ? -b : b;

    always_comb begin
        w_booth = r_acc;
        case ({r_q[0], r_q1})
            2'b01:   w_booth = r_acc + {r_m[WIDTH-1], r_m};
            2'b10:   w_booth = r_acc - {r_m[WIDTH-1], r_m};
            default: w_booth = r_acc;
        endcase
    end

    // Remainder stays below the divisor, so WIDTH bits of r_acc suffice here.
    assign w_div_shift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_m});
    assign w_div_sub   = w_div_shift - {1'b0, r_m};

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_acc_mult)     w_next = S_MULT;
                else if (w_acc_div) w_next = S_DIV;
                else                w_next = S_IDLE;
            end
            S_MULT:  if (r_cnt == c_LAST) w_next = S_FIX;
            S_DIV:   if (r_cnt == c_LAST) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_q1     <= 1'b0;
            r_m      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_div0 <= w_div_zero;
            if (w_acc_mult) begin
                r_cnt    <= '0;
                r_acc    <= '0;
                r_q      <= a;
                r_q1     <= 1'b0;
                r_m      <= b;
                r_is_div <= 1'b0;
            end else if (w_acc_div) begin
                r_cnt    <= '0;
                r_acc    <= '0;
                r_q      <= w_abs_a;
                r_m      <= w_abs_b;
                r_is_div <= 1'b1;
                r_neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                r_neg_r  <= a[WIDTH-1];
            end else begin
                case (r_state)
                    S_MULT: begin
                        r_acc <= {w_booth[WIDTH], w_booth[WIDTH:1]};
                        r_q   <= {w_booth[0], r_q[WIDTH-1:1]};
                        r_q1  <= r_q[0];
                        r_cnt <= r_cnt + 1'b1;
                    end
                    S_DIV: begin
                        r_acc <= w_div_ge ? w_div_sub : w_div_shift;
                        r_q   <= {r_q[WIDTH-2:0], w_div_ge};
                        r_cnt <= r_cnt + 1'b1;
                    end
                    S_FIX: begin
                        if (r_is_div) begin
                            r_lo <= r_neg_q ? -r_q : r_q;
                            r_hi <= r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
                        end else begin
                            r_lo <= r_q;
                            r_hi <= r_acc[WIDTH-1:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy = (r_state == S_MULT) || (r_state == S_DIV) || (r_state == S_FIX);
    assign done = (r_state == S_DONE);
    assign div0 = r_div0;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire
